ex_mdu: RTL
===========

// Module: ex_mdu
// PURPOSE
// - EX-stage multiply/divide unit. Consumes the operand values and MD opcode
//   latched by the ID/EX pipeline register.
// - Owns the HI/LO architectural registers and models fixed multi-cycle
//   latency.
// - Raises busy so the decode stage can stall later MD instructions.
// - hi/lo feed the EX result mux for mfhi/mflo.
// PARAMETERS
// - MULT_CYCLES  5   cycles from start to HI/LO commit for mult-class ops (1..15)
// - DIV_CYCLES   10  cycles from start to HI/LO commit for div-class ops (1..15)
// PORTS
// - clk     in   1   clock
// - reset   in   1   synchronous, active-high
// - start   in   1   EX holds a valid MD instruction this cycle (not a bubble)
// - op      in   4   0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo,
//                    7 madd, 8 maddu, 9 msub, 10 msubu; 11-15 reserved
// - rs_val  in   32  forwarded rs operand (dividend / multiplicand / mt source)
// - rt_val  in   32  forwarded rt operand (divisor / multiplier)
// - busy    out  1   operation in flight
// - hi      out  32  HI register
// - lo      out  32  LO register
// BEHAVIOUR
// - Reset: hi=0, lo=0, busy=0, counter=0, pending result=0. Reset wins over
//   all other inputs, including mid-operation; the in-flight result is
//   discarded.
// - FSM states:
//   - IDLE: busy=0.
//   - RUN: busy=1; counter decrements each edge.
// - IDLE->RUN: at edge T when start=1 and op is arithmetic.
//   - Latches the full 64-bit result into pending {ph,pl}.
//   - Counter = MULT_CYCLES or DIV_CYCLES.
//   - busy is high from after edge T.
// - RUN->IDLE: at the edge where counter==1.
//   - {hi,lo} <= pending; busy <= 0.
//   - Result is visible on hi/lo exactly N cycles after edge T, i.e. busy is
//     high for N cycles.
// - mult/multu: 64-bit signed/unsigned product; hi = [63:32], lo = [31:0].
// - div/divu: lo = quotient, hi = remainder.
//   - Signed div truncates toward zero; the remainder takes the sign of the
//     dividend.
//   - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
// - Divisor zero: op is accepted and busy runs DIV_CYCLES, but hi/lo are left
//   unchanged at commit.
// - mthi/mtlo with start=1 in IDLE: hi (or lo) <= rs_val at that edge. busy
//   stays 0; no latency.
// - start=1 while busy=1: the op is ignored, including mthi/mtlo and
//   arithmetic. Decode guarantees this never happens; the ignore rule is a
//   safety net.
// - start=0, or op==0 or reserved: no effect.
// - hi/lo change only at commit, mthi/mtlo, or reset. Between commits they hold
//   the old values, so an mfhi issued while busy reads the stale value (decode
//   must stall it).
// - All multiply/divide uses behavioural * and / on 33/64-bit extended
//   operands; synthesis timing is out of scope.
// CONFIGURATION
// - MDU_MADD_EN defined: ops 7-10 are legal and use MULT_CYCLES latency.
//   - madd/maddu: {hi,lo} <= {hi,lo} + product (signed/unsigned).
//   - msub/msubu: {hi,lo} <= {hi,lo} - product.
//   - Accumulation uses hi/lo sampled at the start edge, mod 2^64.
// - MDU_MADD_EN undefined: ops 7-10 are treated as reserved (no effect, busy
//   stays 0).
// TESTING
// - mult rs=0xFFFFFFFD rt=5 start 1 cycle
//   -> busy=1 for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1, busy=0.
// - divu rs=7 rt=2 -> after 10 cycles lo=3, hi=1.
// - div rs=0xFFFFFFF9 rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
// - div rs=0x80000000 rt=0xFFFFFFFF -> lo=0x80000000, hi=0.
// - mtlo 0x1234 then div rs=9 rt=0 -> busy 10 cycles; lo stays 0x1234,
//   hi stays 0.
// - multu 0xFFFFFFFF*0xFFFFFFFF, then mthi 0xAAAA at cycle 2 while busy
//   -> mthi ignored; at commit hi=0xFFFFFFFE, lo=0x00000001.
// - Reset asserted at cycle 3 of a mult -> next cycle busy=0, hi=lo=0; no
//   commit afterwards.
// - MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, maddu 1*1 -> hi=1, lo=0 after 5 cycles.
// - MDU_MADD_EN off: op=7 with start=1 -> busy stays 0, hi/lo unchanged.

Source files
------------

// File: rtl/ex_mdu.sv
// EX-stage multiply/divide unit: owns HI/LO and models fixed multi-cycle latency.
// Optional multiply-accumulate ops (madd/maddu/msub/msubu) are enabled by defining MDU_MADD_EN.
module ex_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      state;
  logic [3:0]  count;
  logic [31:0] ph;
  logic [31:0] pl;
  logic        pend_wr;

  logic [63:0]        a_s, b_s, a_u, b_u;
  logic [63:0]        prod_s, prod_u;
  logic signed [32:0] dvd, dvs;
  logic [31:0]        q_s, r_s, q_u, r_u;
  logic               div_zero;

  logic        arith;
  logic [3:0]  lat;
  logic [63:0] res;
  logic        res_wr;

  assign a_s    = {{32{rs_val[31]}}, rs_val};
  assign b_s    = {{32{rt_val[31]}}, rt_val};
  assign a_u    = {32'd0, rs_val};
  assign b_u    = {32'd0, rt_val};
  // The low 64 bits of a two's-complement product are correct for sign-extended operands.
  assign prod_s = a_s * b_s;
  assign prod_u = a_u * b_u;

  // 33-bit signed operands keep 0x80000000 / -1 from overflowing; the low word is the wrapped quotient.
  assign dvd      = {rs_val[31], rs_val};
  assign dvs      = {rt_val[31], rt_val};
  assign div_zero = (rt_val == 32'd0);
  assign q_s      = div_zero ? 32'd0 : 32'(dvd / dvs);
  assign r_s      = div_zero ? 32'd0 : 32'(dvd % dvs);
  assign q_u      = div_zero ? 32'd0 : rs_val / rt_val;
  assign r_u      = div_zero ? 32'd0 : rs_val % rt_val;

  // Decode op into latency, 64-bit result and whether the result is committed.
  always_comb begin
    arith  = 1'b0;
    lat    = 4'(MULT_CYCLES);
    res    = 64'd0;
    res_wr = 1'b1;
    case (op)
      OP_MULT:  begin arith = 1'b1; res = prod_s; end
      OP_MULTU: begin arith = 1'b1; res = prod_u; end
      OP_DIV:   begin arith = 1'b1; lat = 4'(DIV_CYCLES); res = {r_s, q_s}; res_wr = ~div_zero; end
      OP_DIVU:  begin arith = 1'b1; lat = 4'(DIV_CYCLES); res = {r_u, q_u}; res_wr = ~div_zero; end
`ifdef MDU_MADD_EN
      OP_MADD:  begin arith = 1'b1; res = {hi, lo} + prod_s; end
      OP_MADDU: begin arith = 1'b1; res = {hi, lo} + prod_u; end
      OP_MSUB:  begin arith = 1'b1; res = {hi, lo} - prod_s; end
      OP_MSUBU: begin arith = 1'b1; res = {hi, lo} - prod_u; end
`endif
      default:  begin arith = 1'b0; res = 64'd0; end
    endcase
  end

  // Control FSM plus HI/LO and pending-result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      count   <= 4'd0;
      ph      <= 32'd0;
      pl      <= 32'd0;
      pend_wr <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start && arith) begin
            state    <= RUN;
            busy     <= 1'b1;
            count    <= lat;
            {ph, pl} <= res;
            pend_wr  <= res_wr;
          end else if (start && op == OP_MTHI) begin
            hi <= rs_val;
          end else if (start && op == OP_MTLO) begin
            lo <= rs_val;
          end
        end
        RUN: begin
          if (count == 4'd1) begin
            state <= IDLE;
            busy  <= 1'b0;
            count <= 4'd0;
            if (pend_wr) begin
              {hi, lo} <= {ph, pl};
            end
          end else begin
            count <= count - 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
